// File: rtl/mipi_tx_sync_gen.sv
// rtl/mipi_tx_sync_gen.sv - free-running Vsync/Hsync/frame_start source for the MIPI TX timing generator
// Optional genlock to rx_vsync is built in when MIPI_TX_SYNC_EXT_LOCK_EN is defined.
module mipi_tx_sync_gen #(
  parameter int H_TOTAL      = 2200,
  parameter int V_TOTAL      = 1500,
  parameter int VACT_START   = 8,
  parameter int HSYNC_OFFSET = 0
) (
  input  logic        CLK_tx,
  input  logic        RSTn,
  input  logic        sync_en,
  input  logic        rx_frame_ready,
  input  logic        rx_vsync,
  output logic        Vsync,
  output logic        Hsync,
  output logic        frame_start,
  output logic        running,
  output logic [11:0] line_cnt,
  output logic [15:0] frame_cnt,
  output logic [15:0] skip_cnt
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_RUN   = 2'd1;
  localparam logic [1:0]  ST_DRAIN = 2'd2;
  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [15:0] H_SYNC   = 16'(HSYNC_OFFSET);
  localparam logic [11:0] V_ACT    = 12'(VACT_START);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [15:0] r_h_cnt;
  logic [15:0] w_h_nxt;
  logic [11:0] r_v_cnt;
  logic [11:0] w_v_nxt;
  logic        r_arm;
  logic        w_run;
  logic        w_boundary;
  logic        w_lock;
  logic        w_vs_match;
  logic        w_hs_match;
  logic        w_fs_set;
  logic        w_fs_clr;

  assign w_run      = (r_state == ST_RUN);
  assign w_boundary = w_run && (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);

`ifdef MIPI_TX_SYNC_EXT_LOCK_EN
  assign w_lock = w_run & rx_vsync;
`else
  assign w_lock = 1'b0 & rx_vsync;
`endif

  assign w_vs_match = w_run && (r_v_cnt == 12'd0) && (r_h_cnt == H_SYNC);
  assign w_hs_match = w_run && (r_v_cnt != 12'd0) && (r_h_cnt == H_SYNC);
  assign w_fs_set   = w_run && (r_v_cnt == V_ACT) && (r_h_cnt == 16'd0) && r_arm;
  assign w_fs_clr   = w_vs_match || (w_state_nxt == ST_DRAIN) || (r_state == ST_DRAIN);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (sync_en) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_boundary && !sync_en) w_state_nxt = ST_DRAIN;
      ST_DRAIN: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Counters only move in RUN; a genlock hit overrides the normal wrap.
  always_comb begin
    w_h_nxt = 16'd0;
    w_v_nxt = 12'd0;
    if (w_run && !w_lock) begin
      if (r_h_cnt == H_LAST) begin
        w_h_nxt = 16'd0;
        w_v_nxt = (r_v_cnt == V_LAST) ? 12'd0 : r_v_cnt + 12'd1;
      end else begin
        w_h_nxt = r_h_cnt + 16'd1;
        w_v_nxt = r_v_cnt;
      end
    end
  end

  always_ff @(posedge CLK_tx or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= ST_IDLE;
      r_h_cnt     <= 16'd0;
      r_v_cnt     <= 12'd0;
      r_arm       <= 1'b0;
      Vsync       <= 1'b0;
      Hsync       <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
      line_cnt    <= 12'd0;
      frame_cnt   <= 16'd0;
      skip_cnt    <= 16'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_h_cnt  <= w_h_nxt;
      r_v_cnt  <= w_v_nxt;
      Vsync    <= w_vs_match;
      Hsync    <= w_hs_match;
      running  <= (w_state_nxt == ST_RUN);
      line_cnt <= r_v_cnt;
      if (w_vs_match) begin
        r_arm     <= rx_frame_ready;
        frame_cnt <= frame_cnt + 16'd1;
        if (!rx_frame_ready && (skip_cnt != 16'hFFFF)) skip_cnt <= skip_cnt + 16'd1;
      end
      if (w_fs_clr) frame_start <= 1'b0;
      else if (w_fs_set) frame_start <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mipi_tx_sync_gen.sv
// tb/tb_mipi_tx_sync_gen.sv - directed vector bench for mipi_tx_sync_gen (H=16, V=6, VACT=2, offset 0)
module tb_mipi_tx_sync_gen;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sync_en;
  logic        rdy;
  logic        rx_vs;
  logic        vs, hs, fs, run;
  logic [11:0] line;
  logic [15:0] fcnt, scnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mipi_tx_sync_gen #(
    .H_TOTAL(16), .V_TOTAL(6), .VACT_START(2), .HSYNC_OFFSET(0)
  ) dut (
    .CLK_tx(clk), .RSTn(rstn), .sync_en(sync_en), .rx_frame_ready(rdy), .rx_vsync(rx_vs),
    .Vsync(vs), .Hsync(hs), .frame_start(fs), .running(run),
    .line_cnt(line), .frame_cnt(fcnt), .skip_cnt(scnt)
  );

  typedef struct {
    logic        en;
    logic        rdy;
    int          adv;
    logic        vs;
    logic        hs;
    logic        fs;
    logic        run;
    logic [11:0] line;
    logic [15:0] fcnt;
    logic [15:0] scnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic en, logic r, int a, logic v, logic h, logic f, logic rn,
                              logic [11:0] l, logic [15:0] fc, logic [15:0] sc);
    vec_t t;
    t.en = en; t.rdy = r; t.adv = a; t.vs = v; t.hs = h; t.fs = f; t.run = rn;
    t.line = l; t.fcnt = fc; t.scnt = sc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    rstn = 1'b0; sync_en = 1'b0; rdy = 1'b0; rx_vs = 1'b0;

    //      en rdy adv  vs hs fs run line fcnt scnt
    tbl.push_back(mk(1, 1,  1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1,  1, 1, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 1,  1, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 1, 15, 0, 1, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, 1, 16, 0, 1, 1, 1, 2, 1, 0));
    tbl.push_back(mk(1, 1,  1, 0, 0, 1, 1, 2, 1, 0));
    tbl.push_back(mk(1, 1, 47, 0, 1, 1, 1, 5, 1, 0));
    tbl.push_back(mk(1, 1, 15, 0, 0, 1, 1, 5, 1, 0));
    tbl.push_back(mk(1, 1,  1, 1, 0, 0, 1, 0, 2, 0));
    tbl.push_back(mk(1, 1, 32, 0, 1, 1, 1, 2, 2, 0));
    tbl.push_back(mk(1, 1, 62, 0, 0, 1, 1, 5, 2, 0));
    tbl.push_back(mk(1, 0,  2, 1, 0, 0, 1, 0, 3, 1));
    tbl.push_back(mk(1, 0,  1, 0, 0, 0, 1, 0, 3, 1));
    tbl.push_back(mk(1, 1, 31, 0, 1, 0, 1, 2, 3, 1));
    tbl.push_back(mk(1, 1, 64, 1, 0, 0, 1, 0, 4, 1));
    tbl.push_back(mk(1, 1, 32, 0, 1, 1, 1, 2, 4, 1));
    tbl.push_back(mk(0, 1, 16, 0, 1, 1, 1, 3, 4, 1));
    tbl.push_back(mk(0, 1, 46, 0, 0, 1, 1, 5, 4, 1));
    tbl.push_back(mk(0, 1,  1, 0, 0, 0, 0, 5, 4, 1));
    tbl.push_back(mk(0, 1,  1, 0, 0, 0, 0, 0, 4, 1));
    tbl.push_back(mk(0, 1, 15, 0, 0, 0, 0, 0, 4, 1));
    tbl.push_back(mk(1, 1,  1, 0, 0, 0, 1, 0, 4, 1));
    tbl.push_back(mk(1, 1,  1, 1, 0, 0, 1, 0, 5, 1));
    tbl.push_back(mk(1, 1, 64, 0, 1, 1, 1, 4, 5, 1));
    tbl.push_back(mk(1, 1,  1, 0, 0, 1, 1, 4, 5, 1));

    adv(3);
    chk("rst_vs", {31'd0, vs}, 32'd0);
    chk("rst_run", {31'd0, run}, 32'd0);
    chk("rst_fs", {31'd0, fs}, 32'd0);
    chk("rst_cnts", {line, fcnt, scnt[3:0]}, 32'd0);
    rstn = 1'b1;

    foreach (tbl[i]) begin
      sync_en = tbl[i].en;
      rdy     = tbl[i].rdy;
      adv(tbl[i].adv);
      chk($sformatf("vec%0d.vs", i),   {31'd0, vs},  {31'd0, tbl[i].vs});
      chk($sformatf("vec%0d.hs", i),   {31'd0, hs},  {31'd0, tbl[i].hs});
      chk($sformatf("vec%0d.fs", i),   {31'd0, fs},  {31'd0, tbl[i].fs});
      chk($sformatf("vec%0d.run", i),  {31'd0, run}, {31'd0, tbl[i].run});
      chk($sformatf("vec%0d.line", i), {20'd0, line}, {20'd0, tbl[i].line});
      chk($sformatf("vec%0d.fcnt", i), {16'd0, fcnt}, {16'd0, tbl[i].fcnt});
      chk($sformatf("vec%0d.scnt", i), {16'd0, scnt}, {16'd0, tbl[i].scnt});
    end

    // Asynchronous reset at line 4 with frame_start high
    rstn = 1'b0;
    #1;
    chk("async_rst_fs",   {31'd0, fs},  32'd0);
    chk("async_rst_run",  {31'd0, run}, 32'd0);
    chk("async_rst_line", {20'd0, line}, 32'd0);
    chk("async_rst_cnt",  {fcnt, scnt}, 32'd0);
    sync_en = 1'b0; rdy = 1'b0;
    adv(2);
    rstn = 1'b1;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      adv(1);
      if (vs || hs || run) bad++;
    end
    chk("idle_quiet", bad, 32'd0);
    sync_en = 1'b1;
    adv(1);
    chk("restart_run", {31'd0, run}, 32'd1);
    chk("restart_vs0", {31'd0, vs}, 32'd0);
    adv(1);
    chk("restart_vs1", {31'd0, vs}, 32'd1);
    chk("restart_cnt", {fcnt, scnt}, {16'd1, 16'd1});

    // Saturation: preload counters, keep skipping frames
    adv(10);
    force dut.frame_cnt = 16'hFFFE;
    force dut.skip_cnt  = 16'hFFFD;
    #1;
    release dut.frame_cnt;
    release dut.skip_cnt;
    adv(86);
    chk("sat1_vs",  {31'd0, vs}, 32'd1);
    chk("sat1_cnt", {fcnt, scnt}, {16'hFFFF, 16'hFFFE});
    adv(96);
    chk("sat2_cnt", {fcnt, scnt}, {16'h0000, 16'hFFFF});
    adv(96);
    chk("sat3_cnt", {fcnt, scnt}, {16'h0001, 16'hFFFF});

`ifdef MIPI_TX_SYNC_EXT_LOCK_EN
    rdy = 1'b1;
    adv(96);
    chk("lock_pre_vs", {31'd0, vs}, 32'd1);
    adv(54);
    chk("lock_pre_fs", {31'd0, fs}, 32'd1);
    rx_vs = 1'b1;
    adv(1);
    rx_vs = 1'b0;
    chk("lock_vs0", {31'd0, vs}, 32'd0);
    adv(1);
    chk("lock_vs1", {31'd0, vs}, 32'd1);
    chk("lock_fs",  {31'd0, fs}, 32'd0);
    chk("lock_line", {20'd0, line}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mipi_tx_sync_gen.md
Name: mipi_tx_sync_gen

Overview:
- Free-running line/frame timing source in the CLK_tx domain.
- Directly upstream of the MIPI TX timing generator. Drives its Vsync, Hsync and frame_start inputs.
- Vsync/Hsync are one-cycle pulses. frame_start is a level that arms active-line transmission for frames where the pixel FIFO has been primed.
- Starts and stops only on frame boundaries so the downstream command sequencer never sees a truncated frame.

Parameters:
- H_TOTAL, 2200, CLK_tx cycles per line (legal range 16..65535).
- V_TOTAL, 1500, lines per frame, including line 0, which carries Vsync (legal range 4..4095).
- VACT_START, 8, line index at which frame_start rises (legal range 1..V_TOTAL-1).
- HSYNC_OFFSET, 0, h_cnt value at which Hsync/Vsync pulses fire (must be < H_TOTAL).

Ports:
- CLK_tx  in  1  transmit byte clock.
- RSTn  in  1  asynchronous active-low reset.
- sync_en  in  1  level. Enables timing generation; sampled only at frame boundaries.
- rx_frame_ready  in  1  level. Pixel FIFO primed; sampled once per frame.
- rx_vsync  in  1  one-cycle pulse, CLK_tx domain. Used only with the optional feature.
- Vsync  out  1  one-cycle frame pulse.
- Hsync  out  1  one-cycle line pulse.
- frame_start  out  1  level. Active-frame arm for the downstream block.
- running  out  1  generator is producing a frame.
- line_cnt  out  12  current line index (v_cnt).
- frame_cnt  out  16  frames emitted, wraps at 0xFFFF->0.
- skip_cnt  out  16  frames emitted with frame_start low, saturates at 0xFFFF.

Behaviour:
- Reset: every output is 0. Internal counters are 0. The FSM is in IDLE.
- Clock/reset: single clock CLK_tx; reset is asynchronous, active-low (RSTn). All flops are reset asynchronously and released synchronously to CLK_tx.
- Counters:
  - h_cnt is 16 bit and counts 0..H_TOTAL-1, then wraps to 0.
  - v_cnt is 12 bit and increments when h_cnt wraps. It counts 0..V_TOTAL-1, then wraps to 0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: counters are held at 0 and no pulses are emitted. When sync_en=1, the next cycle enters RUN with h_cnt=0 and v_cnt=0.
  - RUN: counters advance.
    - Frame boundary = cycle where h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1.
    - At a frame boundary with sync_en=0, go to DRAIN.
  - DRAIN: lasts exactly one cycle. Clears frame_start, then goes to IDLE.
  - A sync_en drop mid-frame has no effect until the frame boundary.
- running = 1 in RUN, 0 otherwise (registered).
- Pulses (registered, 1-cycle latency from the counter match):
  - Vsync = 1 when in RUN, v_cnt==0 and h_cnt==HSYNC_OFFSET.
  - Hsync = 1 when in RUN, v_cnt!=0 and h_cnt==HSYNC_OFFSET.
  - Vsync and Hsync are never high in the same cycle.
- frame_start:
  - rx_frame_ready is sampled into arm_q on the Vsync cycle.
  - frame_start sets to 1 on the cycle where v_cnt==VACT_START, h_cnt==0 and arm_q=1.
  - It clears on the Vsync pulse, in DRAIN, and on reset. Clear has priority over set.
  - Later changes to rx_frame_ready within the frame are ignored.
- Counter updates:
  - frame_cnt increments on every Vsync.
  - skip_cnt increments on a Vsync whose sampled rx_frame_ready=0; it saturates.
- line_cnt mirrors v_cnt (registered, same timing as Hsync).
- Reset mid-frame: all outputs drop immediately. After release, the block restarts from IDLE.

Optional Feature:
- Macro MIPI_TX_SYNC_EXT_LOCK_EN.
- When defined (genlock), an rx_vsync pulse in RUN forces h_cnt=0 and v_cnt=0 on the next cycle.
  - This takes priority over the normal wrap.
  - The following Vsync pulse is emitted at HSYNC_OFFSET as usual.
  - rx_vsync in IDLE is ignored.
- When undefined, rx_vsync is unused and the generator free-runs; no genlock logic is synthesized.

Test Plan:
- Parameters H_TOTAL=16, V_TOTAL=6, VACT_START=2, HSYNC_OFFSET=0.
  - Stimulus: release reset, sync_en=1, rx_frame_ready=1.
  - Required: Vsync every 96 cycles; Hsync 5 times per frame at 16-cycle spacing; frame_start rises at line 2, h_cnt=0; frame_cnt=3 after 3 frames.
- rx_frame_ready=0 during Vsync, then 1 mid-frame -> frame_start stays 0 for that frame; skip_cnt increments by 1; the next frame arms normally.
- sync_en dropped at line 3 -> frame completes through line 5; DRAIN lasts one cycle; running=0; no further pulses; re-enable restarts with Vsync 1 cycle after RUN entry.
- RSTn asserted at line 4 with frame_start=1 -> all outputs 0 asynchronously (same cycle); after release, the next Vsync appears only once sync_en is seen in IDLE.
- With MIPI_TX_SYNC_EXT_LOCK_EN: rx_vsync pulse at line 3, h_cnt=7 -> counters reset; Vsync 2 cycles after the rx_vsync pulse; frame_start cleared.
- skip_cnt preset near saturation by running 65535+2 skipped frames (accelerated with V_TOTAL=4, H_TOTAL=16) -> holds at 0xFFFF while frame_cnt wraps.
